// File: rtl/rr_merge2.sv
// Two-input round-robin stream merger with packet locking and a registered output stage.
// Each output beat carries the index of the input it came from.
module rr_merge2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready,
    output logic [1:0]       dbg_state
);

    // Handshake: a beat moves when valid && ready at a rising edge; a source
    // holds valid/data/last stable until then, and valid never waits on ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_gnt;
    logic             gnt;
    logic             gnt_vld;
    logic             free;
    logic             acc;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;

    // In IDLE a tie goes to the input that was not granted most recently.
    always_comb begin
        gnt     = 1'b0;
        gnt_vld = 1'b0;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    gnt     = ~last_gnt;
                    gnt_vld = 1'b1;
                end else if (in0_valid) begin
                    gnt     = 1'b0;
                    gnt_vld = 1'b1;
                end else if (in1_valid) begin
                    gnt     = 1'b1;
                    gnt_vld = 1'b1;
                end
            end
            LOCK0: begin
                gnt     = 1'b0;
                gnt_vld = 1'b1;
            end
            LOCK1: begin
                gnt     = 1'b1;
                gnt_vld = 1'b1;
            end
            default: begin
                gnt     = 1'b0;
                gnt_vld = 1'b0;
            end
        endcase
    end

    assign free = !out_valid || out_ready;

    assign in0_ready = rst_n && free && gnt_vld && !gnt &&
                       ((state == LOCK0) || ((state == IDLE) && in0_valid));
    assign in1_ready = rst_n && free && gnt_vld && gnt &&
                       ((state == LOCK1) || ((state == IDLE) && in1_valid));

    assign acc      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    assign acc_data = gnt ? in1_data : in0_data;
    assign acc_last = gnt ? in1_last : in0_last;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc && !acc_last) begin
                    state_nxt = gnt ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (acc && acc_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (acc) begin
                last_gnt <= gnt;
            end
        end
    end

    // Output stage: load on accept, drain when consumed, otherwise freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= acc_data;
            out_last  <= acc_last;
            out_src   <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign dbg_state = state;

endmodule
